secded_codec: RTL and testbench

SECDED_CODEC -- requirements
Module: secded_codec

---
 rtl/secded_codec_if.sv | 34 +++
 rtl/secded_codec.sv | 192 +++++++++++++++++++
 tb/tb_secded_codec.sv | 358 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/secded_codec_if.sv
// Handshake bundle for secded_codec: input word channel and result channel.
// CODE_W is derived here the same way as in the codec so both agree for a given DATA_W.
interface secded_codec_if #(
  parameter int unsigned DATA_W = 8
);
  function automatic int unsigned calc_r(input int unsigned dw);
    int unsigned r;
    r = 1;
    while ((32'd1 << r) < dw + r + 1) r++;
    return r;
  endfunction

  localparam int unsigned R      = calc_r(DATA_W);
  localparam int unsigned CODE_W = DATA_W + R + 1;

  logic              in_valid;
  logic              in_ready;
  logic              in_mode;
  logic [CODE_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [CODE_W-1:0] out_data;
  logic [1:0]        out_status;

  modport master (
    output in_valid, in_mode, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_status
  );

  modport slave (
    input  in_valid, in_mode, in_data, out_ready,
    output in_ready, out_valid, out_data, out_status
  );
endinterface

// File: rtl/secded_codec.sv
// Hamming SECDED encoder/decoder with a 2-stage valid/ready pipeline and
// saturating corrected/uncorrectable error counters.
module secded_codec #(
  parameter int unsigned DATA_W = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  secded_codec_if.slave       bus,
  input  logic                clr_cnt,
  output logic [7:0]          corr_cnt,
  output logic [7:0]          uncorr_cnt
);
  function automatic int unsigned calc_r(input int unsigned dw);
    int unsigned r;
    r = 1;
    while ((32'd1 << r) < dw + r + 1) r++;
    return r;
  endfunction

  localparam int unsigned R      = calc_r(DATA_W);
  localparam int unsigned CODE_W = DATA_W + R + 1;

  localparam logic [1:0] ST_OK     = 2'b00;
  localparam logic [1:0] ST_CORR   = 2'b01;
  localparam logic [1:0] ST_UNCORR = 2'b10;

  // Per parity group k: XOR of every bit whose 1-indexed position has bit k set.
  function automatic logic [R-1:0] syndrome(input logic [CODE_W-1:0] w);
    logic [CODE_W-1:0] ww;
    logic [R-1:0]      s;
    ww = w;
    s  = '0;
    for (int unsigned pos = 1; pos < CODE_W; pos++) begin
      for (int unsigned k = 0; k < R; k++) begin
        if (((pos >> k) & 32'd1) != 0) s = s ^ (R'(ww[0]) << k);
      end
      ww = ww >> 1;
    end
    return s;
  endfunction

  function automatic logic [CODE_W-1:0] encode(input logic [DATA_W-1:0] d);
    logic [CODE_W-1:0] cw;
    logic [DATA_W-1:0] dd;
    logic [R-1:0]      s;
    cw = '0;
    dd = d;
    for (int unsigned pos = 1; pos < CODE_W; pos++) begin
      if ((pos & (pos - 1)) != 0) begin
        cw = cw | (CODE_W'(dd[0]) << (pos - 1));
        dd = dd >> 1;
      end
    end
    // Parity slots are still zero, so the syndrome equals the required parity bits.
    s = syndrome(cw);
    for (int unsigned k = 0; k < R; k++) begin
      cw = cw | (CODE_W'(s[0]) << ((32'd1 << k) - 1));
      s  = s >> 1;
    end
    cw[CODE_W-1] = ^cw[CODE_W-2:0];
    return cw;
  endfunction

  function automatic logic [DATA_W-1:0] extract(input logic [CODE_W-1:0] w);
    logic [CODE_W-1:0] ww;
    logic [DATA_W-1:0] d;
    int unsigned       j;
    ww = w;
    d  = '0;
    j  = 0;
    for (int unsigned pos = 1; pos < CODE_W; pos++) begin
      if ((pos & (pos - 1)) != 0) begin
        d = d | (DATA_W'(ww[0]) << j);
        j++;
      end
      ww = ww >> 1;
    end
    return d;
  endfunction

  logic              s1_valid_q, s1_valid_d;
  logic              s1_mode_q, s1_mode_d;
  logic [CODE_W-1:0] s1_word_q, s1_word_d;
  logic [R-1:0]      s1_syn_q, s1_syn_d;
  logic              s1_par_q, s1_par_d;
  logic              out_valid_q, out_valid_d;
  logic [CODE_W-1:0] out_data_q, out_data_d;
  logic [1:0]        out_status_q, out_status_d;
  logic [7:0]        corr_q, corr_d;
  logic [7:0]        uncorr_q, uncorr_d;

  logic              s2_adv_c;
  logic              s1_adv_c;
  logic              out_hs_c;
  logic [CODE_W-1:0] fixed_c;
  logic [1:0]        dec_st_c;

  assign s2_adv_c = !out_valid_q || bus.out_ready;
  assign s1_adv_c = !s1_valid_q || s2_adv_c;
  assign out_hs_c = out_valid_q && bus.out_ready;

  assign bus.in_ready   = s1_adv_c;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_data   = out_data_q;
  assign bus.out_status = out_status_q;
  assign corr_cnt       = corr_q;
  assign uncorr_cnt     = uncorr_q;

  // Decode classification and single-bit correction from the stage-1 syndrome.
  always_comb begin
    fixed_c  = s1_word_q;
    dec_st_c = ST_OK;
    if (s1_par_q) begin
      if (s1_syn_q == '0) begin
        dec_st_c = ST_CORR;
      end else if (32'(s1_syn_q) <= CODE_W - 1) begin
        fixed_c  = s1_word_q ^ (CODE_W'(1) << (s1_syn_q - R'(1)));
        dec_st_c = ST_CORR;
      end else begin
        dec_st_c = ST_UNCORR;
      end
    end else if (s1_syn_q != '0) begin
      dec_st_c = ST_UNCORR;
    end
  end

  always_comb begin
    s1_valid_d   = s1_valid_q;
    s1_mode_d    = s1_mode_q;
    s1_word_d    = s1_word_q;
    s1_syn_d     = s1_syn_q;
    s1_par_d     = s1_par_q;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_status_d = out_status_q;
    corr_d       = corr_q;
    uncorr_d     = uncorr_q;

    if (s1_adv_c) begin
      s1_valid_d = bus.in_valid;
      if (bus.in_valid) begin
        s1_mode_d = bus.in_mode;
        s1_word_d = bus.in_data;
        s1_syn_d  = syndrome(bus.in_data);
        s1_par_d  = ^bus.in_data;
      end
    end

    if (s2_adv_c) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        out_data_d   = s1_mode_q ? CODE_W'(extract(fixed_c)) : encode(s1_word_q[DATA_W-1:0]);
        out_status_d = s1_mode_q ? dec_st_c : ST_OK;
      end
    end

    // Clear takes priority over a same-cycle increment.
    if (clr_cnt) begin
      corr_d   = '0;
      uncorr_d = '0;
    end else if (out_hs_c) begin
      if (out_status_q == ST_CORR && corr_q != 8'hFF) corr_d = corr_q + 8'd1;
      if (out_status_q == ST_UNCORR && uncorr_q != 8'hFF) uncorr_d = uncorr_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_q   <= 1'b0;
      s1_mode_q    <= 1'b0;
      s1_word_q    <= '0;
      s1_syn_q     <= '0;
      s1_par_q     <= 1'b0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_status_q <= ST_OK;
      corr_q       <= '0;
      uncorr_q     <= '0;
    end else begin
      s1_valid_q   <= s1_valid_d;
      s1_mode_q    <= s1_mode_d;
      s1_word_q    <= s1_word_d;
      s1_syn_q     <= s1_syn_d;
      s1_par_q     <= s1_par_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_status_q <= out_status_d;
      corr_q       <= corr_d;
      uncorr_q     <= uncorr_d;
    end
  end
endmodule

// File: tb/tb_secded_codec.sv
// Directed bench for secded_codec at DATA_W = 4, 8 and 32 sharing one clock and reset.
module tb_secded_codec;
  logic        clk;
  logic        rst_n;
  logic        iv[3];
  logic        im[3];
  logic        ordy[3];
  logic        clr[3];
  logic [63:0] id[3];
  logic [7:0]  corr4, uncorr4, corr8, uncorr8, corr32, uncorr32;
  int          n_cmp;
  int          n_bad;

  secded_codec_if #(.DATA_W(4))  b4 ();
  secded_codec_if #(.DATA_W(8))  b8 ();
  secded_codec_if #(.DATA_W(32)) b32 ();

  assign b4.in_valid   = iv[0];
  assign b4.in_mode    = im[0];
  assign b4.in_data    = id[0][7:0];
  assign b4.out_ready  = ordy[0];
  assign b8.in_valid   = iv[1];
  assign b8.in_mode    = im[1];
  assign b8.in_data    = id[1][12:0];
  assign b8.out_ready  = ordy[1];
  assign b32.in_valid  = iv[2];
  assign b32.in_mode   = im[2];
  assign b32.in_data   = id[2][38:0];
  assign b32.out_ready = ordy[2];

  secded_codec #(.DATA_W(4)) u4 (
    .clk(clk), .rst_n(rst_n), .bus(b4.slave),
    .clr_cnt(clr[0]), .corr_cnt(corr4), .uncorr_cnt(uncorr4)
  );
  secded_codec #(.DATA_W(8)) u8 (
    .clk(clk), .rst_n(rst_n), .bus(b8.slave),
    .clr_cnt(clr[1]), .corr_cnt(corr8), .uncorr_cnt(uncorr8)
  );
  secded_codec #(.DATA_W(32)) u32 (
    .clk(clk), .rst_n(rst_n), .bus(b32.slave),
    .clr_cnt(clr[2]), .corr_cnt(corr32), .uncorr_cnt(uncorr32)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic rdy(input int w);
    logic r;
    case (w)
      0:       r = b4.in_ready;
      1:       r = b8.in_ready;
      default: r = b32.in_ready;
    endcase
    return r;
  endfunction

  function automatic logic ov(input int w);
    logic r;
    case (w)
      0:       r = b4.out_valid;
      1:       r = b8.out_valid;
      default: r = b32.out_valid;
    endcase
    return r;
  endfunction

  function automatic logic [63:0] od(input int w);
    logic [63:0] r;
    case (w)
      0:       r = 64'(b4.out_data);
      1:       r = 64'(b8.out_data);
      default: r = 64'(b32.out_data);
    endcase
    return r;
  endfunction

  function automatic logic [1:0] ost(input int w);
    logic [1:0] r;
    case (w)
      0:       r = b4.out_status;
      1:       r = b8.out_status;
      default: r = b32.out_status;
    endcase
    return r;
  endfunction

  function automatic int codew(input int dw);
    int r;
    r = 1;
    while ((1 << r) < dw + r + 1) r++;
    return dw + r + 1;
  endfunction

  // Reference encoder: parity bits are the XOR of the positions of all set data bits.
  function automatic logic [63:0] m_enc(input int dw, input logic [63:0] d);
    int          cww, j, syn;
    logic [63:0] cw;
    cww = codew(dw);
    j   = 0;
    syn = 0;
    cw  = '0;
    for (int pos = 1; pos < cww; pos++) begin
      if ((pos & (pos - 1)) != 0) begin
        cw[6'(pos - 1)] = d[6'(j)];
        if (d[6'(j)]) syn = syn ^ pos;
        j++;
      end
    end
    for (int k = 0; k < 6; k++) begin
      if (((syn >> k) & 1) == 1) cw[6'((1 << k) - 1)] = 1'b1;
    end
    cw[6'(cww - 1)] = ^cw;
    return cw;
  endfunction

  function automatic logic [63:0] m_ext(input int dw, input logic [63:0] cw);
    int          cww, j;
    logic [63:0] d;
    cww = codew(dw);
    j   = 0;
    d   = '0;
    for (int pos = 1; pos < cww; pos++) begin
      if ((pos & (pos - 1)) != 0) begin
        d[6'(j)] = cw[6'(pos - 1)];
        j++;
      end
    end
    return d;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One word in, one result out; lat counts falling edges from input handshake to out_valid.
  task automatic txn(input int w, input logic [63:0] din, input logic mode,
                     output logic [63:0] dout, output logic [1:0] st, output int lat);
    int cyc;
    @(negedge clk);
    iv[w]   = 1'b1;
    id[w]   = din;
    im[w]   = mode;
    ordy[w] = 1'b1;
    #1;
    cyc = 0;
    while (!rdy(w) && cyc < 20) begin
      @(negedge clk);
      #1;
      cyc++;
    end
    chk("txn_in_ready", 64'(rdy(w)), 64'd1);
    @(posedge clk);
    #1;
    iv[w] = 1'b0;
    lat = 0;
    while (!ov(w) && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("txn_out_valid", 64'(ov(w)), 64'd1);
    dout = od(w);
    st   = ost(w);
    @(posedge clk);
    #1;
  endtask

  task automatic sweep(input int w, input int dw, input logic [63:0] d);
    logic [63:0] cw, rx, dout;
    logic [1:0]  st;
    int          lat, cww;
    cww = codew(dw);
    cw  = m_enc(dw, d);
    txn(w, d, 1'b0, dout, st, lat);
    chk("sweep_enc", dout, cw);
    for (int b = 0; b < cww; b++) begin
      rx = cw ^ (64'd1 << b);
      txn(w, rx, 1'b1, dout, st, lat);
      chk("single_data", dout, d);
      chk("single_status", 64'(st), 64'd1);
    end
    for (int a = 0; a < cww; a++) begin
      for (int b = a + 1; b < cww; b++) begin
        rx = cw ^ (64'd1 << a) ^ (64'd1 << b);
        txn(w, rx, 1'b1, dout, st, lat);
        chk("double_data", dout, m_ext(dw, rx));
        chk("double_status", 64'(st), 64'd2);
      end
    end
  endtask

  logic [63:0] dout, held;
  logic [1:0]  st;
  int          lat, sent, recv, cyc;
  logic        stall, seen;

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      iv[i] = 1'b0; im[i] = 1'b0; ordy[i] = 1'b1; clr[i] = 1'b0; id[i] = '0;
    end

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 64'(ov(0)), 64'd0);
    chk("rst_out_data", od(0), 64'd0);
    chk("rst_out_status", 64'(ost(0)), 64'd0);
    chk("rst_corr", 64'(corr4), 64'd0);
    chk("rst_uncorr", 64'(uncorr4), 64'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rel_in_ready", 64'(rdy(0)), 64'd1);

    // Directed DATA_W=4 vectors
    txn(0, 64'hB, 1'b0, dout, st, lat);
    chk("enc_b_data", dout, 64'h55);
    chk("enc_b_status", 64'(st), 64'd0);
    chk("enc_b_latency", 64'(lat), 64'd2);
    txn(0, 64'h55, 1'b1, dout, st, lat);
    chk("dec_55_data", dout, 64'hB);
    chk("dec_55_status", 64'(st), 64'd0);
    txn(0, 64'h51, 1'b1, dout, st, lat);
    chk("dec_51_data", dout, 64'hB);
    chk("dec_51_status", 64'(st), 64'd1);
    chk("dec_51_corr", 64'(corr4), 64'd1);
    txn(0, 64'hD5, 1'b1, dout, st, lat);
    chk("dec_d5_data", dout, 64'hB);
    chk("dec_d5_status", 64'(st), 64'd1);
    chk("dec_d5_corr", 64'(corr4), 64'd2);
    txn(0, 64'h50, 1'b1, dout, st, lat);
    chk("dec_50_data", dout, 64'hA);
    chk("dec_50_status", 64'(st), 64'd2);
    chk("dec_50_uncorr", 64'(uncorr4), 64'd1);
    chk("dec_50_corr", 64'(corr4), 64'd2);
    txn(0, 64'hF3, 1'b0, dout, st, lat);
    chk("enc_3_data", dout, 64'h1E);
    chk("enc_3_corr", 64'(corr4), 64'd2);
    chk("enc_3_uncorr", 64'(uncorr4), 64'd1);

    // Back-to-back stream with out_ready pattern 1,0,0,...
    sent = 0; recv = 0; cyc = 0; stall = 1'b0; held = '0;
    while (recv < 16 && cyc < 300) begin
      @(negedge clk);
      ordy[0] = (cyc % 3 == 0);
      iv[0]   = (sent < 16);
      id[0]   = 64'(sent);
      im[0]   = 1'b0;
      #1;
      if (stall) begin
        chk("stall_valid", 64'(ov(0)), 64'd1);
        chk("stall_hold", od(0), held);
      end
      if (ov(0) && ordy[0]) begin
        chk("stream_data", od(0), m_enc(4, 64'(recv)));
        recv++;
      end
      stall = ov(0) && !ordy[0];
      held  = od(0);
      if (iv[0] && rdy(0)) sent++;
      cyc++;
    end
    @(negedge clk);
    iv[0] = 1'b0;
    ordy[0] = 1'b1;
    chk("stream_count", 64'(recv), 64'd16);
    repeat (3) @(negedge clk);
    chk("stream_no_dup", 64'(ov(0)), 64'd0);

    // Counter clear, then saturation
    @(negedge clk);
    clr[0] = 1'b1;
    @(posedge clk);
    #1;
    clr[0] = 1'b0;
    chk("clr_corr", 64'(corr4), 64'd0);
    chk("clr_uncorr", 64'(uncorr4), 64'd0);
    sent = 0; cyc = 0;
    while (sent < 300 && cyc < 1000) begin
      @(negedge clk);
      iv[0] = 1'b1; id[0] = 64'h51; im[0] = 1'b1;
      #1;
      if (rdy(0)) sent++;
      cyc++;
    end
    @(negedge clk);
    iv[0] = 1'b0;
    repeat (5) @(negedge clk);
    chk("sat_corr", 64'(corr4), 64'd255);
    chk("sat_uncorr", 64'(uncorr4), 64'd0);

    // Clear coincident with a corrected delivery
    ordy[0] = 1'b0;
    iv[0] = 1'b1; id[0] = 64'h51; im[0] = 1'b1;
    @(posedge clk);
    #1;
    iv[0] = 1'b0;
    cyc = 0;
    while (!ov(0) && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    chk("clr_hs_valid", 64'(ov(0)), 64'd1);
    @(negedge clk);
    ordy[0] = 1'b1;
    clr[0]  = 1'b1;
    @(posedge clk);
    #1;
    clr[0] = 1'b0;
    chk("clr_wins", 64'(corr4), 64'd0);
    txn(0, 64'h51, 1'b1, dout, st, lat);
    chk("clr_resume", 64'(corr4), 64'd1);

    // Fill both stages under backpressure, then reset mid-stream
    ordy[0] = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      iv[0] = 1'b1; id[0] = 64'(i); im[0] = 1'b0;
    end
    @(negedge clk);
    iv[0] = 1'b0;
    #1;
    chk("full_valid", 64'(ov(0)), 64'd1);
    chk("full_in_ready", 64'(rdy(0)), 64'd0);
    chk("full_hold", od(0), m_enc(4, 64'd1));
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("mid_rst_valid", 64'(ov(0)), 64'd0);
    chk("mid_rst_data", od(0), 64'd0);
    chk("mid_rst_corr", 64'(corr4), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    ordy[0] = 1'b1;
    seen = 1'b0;
    repeat (5) begin
      @(negedge clk);
      seen = seen | ov(0);
    end
    chk("mid_rst_discard", 64'(seen), 64'd0);
    chk("mid_rst_ready", 64'(rdy(0)), 64'd1);

    // Exhaustive single/double flips on wider codecs
    sweep(1, 8, 64'hA5);
    sweep(1, 8, 64'($urandom_range(255)));
    sweep(2, 32, 64'hDEADBEEF);
    sweep(2, 32, 64'($urandom));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
